// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and
// buffers each returned word in a registered IF/ID slot toward decode.
module fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [6:0]      id_opcode
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            kill_q, kill_d;
   logic            req_q, req_d;
   logic            valid_q, valid_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] id_pc_q, id_pc_d;
   logic [XLEN-1:0] redirect_target;

   assign redirect_target = redirect_pc & ~XLEN'(3);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         kill_q  <= 1'b0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         instr_q <= NOP;
         id_pc_q <= '0;
      end else begin
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         id_pc_q <= id_pc_d;
      end
   end

   // NOTE: every signal gets a default before the case so no path through
   // this block leaves one unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      kill_d  = kill_q;
      valid_d = valid_q;
      instr_d = instr_q;
      id_pc_d = id_pc_q;

      unique case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ:  state_d = S_WAIT;
         S_WAIT: begin
            if (imem_rvalid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  instr_d = imem_rdata;
                  id_pc_d = pc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q + XLEN'(4);
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (id_ready) begin
               valid_d = 1'b0;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A redirect overrides whatever the state-specific logic decided,
      // including a same-cycle decode handshake or memory response.
      if (redirect_valid) begin
         pc_d    = redirect_target;
         valid_d = 1'b0;
         instr_d = NOP;
         unique case (state_q)
            S_REQ: begin
               kill_d  = 1'b1;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               kill_d  = ~imem_rvalid;
               state_d = imem_rvalid ? S_REQ : S_WAIT;
            end
            default: begin
               kill_d  = 1'b0;
               state_d = S_REQ;
            end
         endcase
      end
   end

   // The request flop mirrors "next state is REQ" so imem_req stays registered.
   assign req_d = (state_d == S_REQ);

   assign imem_req  = req_q;
   assign imem_addr = pc_q;
   assign id_valid  = valid_q;
   assign id_instr  = instr_q;
   assign id_pc     = id_pc_q;
   assign id_opcode = instr_q[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed walk through boot, backpressure, redirect and reset corners, then a
// randomized phase scored against a transaction-level fetch model.
module tb_fetch_unit;

   localparam logic [31:0] BOOT_PC = 32'h0000_0100;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [6:0]  id_opcode;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_t;

   fetch_t      slot_q[$];
   logic [31:0] exp_pc;
   logic        exp_req;
   logic        pending;
   logic        pend_killed;
   logic [31:0] pend_addr;
   int          pend_wait;
   logic        rv;

   fetch_unit #(
      .XLEN     (32),
      .RESET_PC (BOOT_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_opcode      (id_opcode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_1357;
   endfunction

   initial begin
      reset          = 1'b1;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b0;
      repeat (2) @(negedge clk);

      // Reset values
      check("rst_req",    imem_req,  0);
      check("rst_addr",   imem_addr, BOOT_PC);
      check("rst_valid",  id_valid,  0);
      check("rst_instr",  id_instr,  NOP);
      check("rst_pc",     id_pc,     0);
      check("rst_opcode", id_opcode, 32'h13);

      // Boot: cycle 0 is IDLE
      reset    = 1'b0;
      id_ready = 1'b1;
      @(negedge clk);                                   // cycle 1
      check("boot_req",  imem_req,  1);
      check("boot_addr", imem_addr, BOOT_PC);
      @(negedge clk);                                   // cycle 2
      check("boot_wait_req", imem_req, 0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0050_0093;
      @(negedge clk);                                   // cycle 3
      imem_rvalid = 1'b0;
      check("boot_valid",  id_valid,  1);
      check("boot_pc",     id_pc,     32'h100);
      check("boot_instr",  id_instr,  32'h0050_0093);
      check("boot_opcode", id_opcode, 32'h13);
      check("boot_nextpc", imem_addr, 32'h104);
      check("boot_noreq",  imem_req,  0);
      @(negedge clk);                                   // cycle 4
      check("boot_req2",   imem_req,  1);
      check("boot_addr2",  imem_addr, 32'h104);
      check("boot_clear",  id_valid,  0);

      // Backpressure
      id_ready = 1'b0;
      @(negedge clk);                                   // cycle 5
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h00a0_0113;
      @(negedge clk);                                   // cycle 6
      imem_rvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", id_valid, 1);
         check("bp_pc",    id_pc,    32'h104);
         check("bp_instr", id_instr, 32'h00a0_0113);
         check("bp_noreq", imem_req, 0);
         @(negedge clk);
      end
      check("bp_still_valid", id_valid, 1);
      id_ready = 1'b1;
      @(negedge clk);                                   // cycle 12
      check("bp_req",   imem_req,  1);
      check("bp_addr",  imem_addr, 32'h108);
      check("bp_clear", id_valid,  0);
      id_ready = 1'b0;

      // Redirect in first WAIT cycle, memory latency 3
      @(negedge clk);                                   // cycle 13
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      @(negedge clk);                                   // cycle 14
      redirect_valid = 1'b0;
      check("rw_valid", id_valid,  0);
      check("rw_noreq", imem_req,  0);
      check("rw_addr",  imem_addr, 32'h200);
      check("rw_nop",   id_instr,  NOP);
      @(negedge clk);                                   // cycle 15
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hdead_beef;
      @(negedge clk);                                   // cycle 16
      imem_rvalid = 1'b0;
      check("rw_drop_valid", id_valid,  0);
      check("rw_req",        imem_req,  1);
      check("rw_req_addr",   imem_addr, 32'h200);
      @(negedge clk);                                   // cycle 17
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0010_0513;
      @(negedge clk);                                   // cycle 18
      imem_rvalid = 1'b0;
      check("rw_deliv_valid", id_valid, 1);
      check("rw_deliv_pc",    id_pc,    32'h200);
      check("rw_deliv_instr", id_instr, 32'h0010_0513);
      id_ready = 1'b1;
      @(negedge clk);                                   // cycle 19
      check("rw_next_req",  imem_req,  1);
      check("rw_next_addr", imem_addr, 32'h204);
      id_ready = 1'b0;

      // Redirect together with the response
      @(negedge clk);                                   // cycle 20
      imem_rvalid    = 1'b1;
      imem_rdata     = 32'h1234_5678;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      @(negedge clk);                                   // cycle 21
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      check("rv_valid", id_valid,  0);
      check("rv_req",   imem_req,  1);
      check("rv_addr",  imem_addr, 32'h300);
      @(negedge clk);                                   // cycle 22
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0020_0593;
      @(negedge clk);                                   // cycle 23
      imem_rvalid = 1'b0;
      check("rh_valid", id_valid, 1);
      check("rh_pc",    id_pc,    32'h300);
      // Redirect together with the decode handshake
      id_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h400;
      @(negedge clk);                                   // cycle 24
      redirect_valid = 1'b0;
      id_ready       = 1'b0;
      check("rh_flush", id_valid,  0);
      check("rh_nop",   id_instr,  NOP);
      check("rh_req",   imem_req,  1);
      check("rh_addr",  imem_addr, 32'h400);

      // Redirect during REQ to an unaligned top-of-memory target, then wrap
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFF;
      @(negedge clk);                                   // cycle 25
      redirect_valid = 1'b0;
      check("wr_addr",  imem_addr, 32'hFFFF_FFFC);
      check("wr_noreq", imem_req,  0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hbad0_bad0;
      @(negedge clk);                                   // cycle 26
      imem_rvalid = 1'b0;
      check("wr_req",      imem_req,  1);
      check("wr_req_addr", imem_addr, 32'hFFFF_FFFC);
      check("wr_killed",   id_valid,  0);
      @(negedge clk);                                   // cycle 27
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0030_0613;
      @(negedge clk);                                   // cycle 28
      imem_rvalid = 1'b0;
      check("wr_valid",  id_valid,  1);
      check("wr_pc",     id_pc,     32'hFFFF_FFFC);
      check("wr_nextpc", imem_addr, 32'h0);
      id_ready = 1'b1;
      @(negedge clk);                                   // cycle 29
      check("wr_req2",  imem_req,  1);
      check("wr_addr2", imem_addr, 32'h0);
      id_ready = 1'b0;

      // Async reset in WAIT with a response still owed
      @(negedge clk);                                   // cycle 30
      #2 reset = 1'b1;
      #1;
      check("ar_addr",   imem_addr, BOOT_PC);
      check("ar_req",    imem_req,  0);
      check("ar_valid",  id_valid,  0);
      check("ar_pc",     id_pc,     0);
      check("ar_instr",  id_instr,  NOP);
      check("ar_opcode", id_opcode, 32'h13);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0040_0693;
      @(negedge clk);
      reset = 1'b0;                                     // IDLE, late response
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("ar_late_valid", id_valid,  0);
      check("ar_late_req",   imem_req,  1);
      check("ar_late_addr",  imem_addr, BOOT_PC);

      // Randomized phase against the transaction-level model
      reset = 1'b1;
      @(negedge clk);
      reset       = 1'b0;
      exp_pc      = BOOT_PC;
      exp_req     = 1'b0;
      pending     = 1'b0;
      pend_killed = 1'b0;
      pend_addr   = '0;
      pend_wait   = 0;
      slot_q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         check("rnd_req",   imem_req,  32'(exp_req));
         check("rnd_addr",  imem_addr, exp_pc);
         check("rnd_valid", id_valid,  32'(slot_q.size() != 0));
         if (slot_q.size() != 0) begin
            check("rnd_pc",     id_pc,     slot_q[0].pc);
            check("rnd_instr",  id_instr,  slot_q[0].instr);
            check("rnd_opcode", id_opcode, 32'(slot_q[0].instr[6:0]));
         end

         if (exp_req) begin
            pending     = 1'b1;
            pend_addr   = exp_pc;
            pend_killed = 1'b0;
            pend_wait   = int'($urandom_range(0, 2));
            rv          = 1'b0;
         end else if (pending) begin
            if (pend_wait == 0) begin
               rv = 1'b1;
            end else begin
               rv = 1'b0;
               pend_wait--;
            end
         end else begin
            rv = ($urandom_range(0, 9) == 0);           // stray pulse, must be ignored
         end
         imem_rvalid    = rv;
         imem_rdata     = (rv && pending) ? mem_word(pend_addr) : $urandom;
         id_ready       = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 7) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ?
                          (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;

         if (redirect_valid) begin
            exp_pc = redirect_pc & ~32'h3;
            slot_q.delete();
            if (pending) begin
               if (rv) pending = 1'b0;
               else    pend_killed = 1'b1;
            end
         end else begin
            if (slot_q.size() != 0 && id_ready) void'(slot_q.pop_front());
            if (pending && rv) begin
               pending = 1'b0;
               if (!pend_killed) begin
                  slot_q.push_back('{pc: pend_addr, instr: mem_word(pend_addr)});
                  exp_pc = pend_addr + 32'd4;
               end
            end
         end
         exp_req = !pending && (slot_q.size() == 0);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core. It holds the program counter and issues one instruction-memory read at a time. Each returned word is buffered into a registered IF/ID slot with a valid/ready handshake toward decode. `id_opcode` drives the main decoder/controller directly. Taken branches and jumps from execute redirect the PC and squash any fetch in flight.

## Interface
- `XLEN`, default 32: PC and instruction width.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be 4-byte aligned.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `imem_req`, output, 1: read request; registered; high for exactly one cycle per fetch.
- `imem_addr`, output, XLEN: fetch address (current PC); stable from the request cycle until the response.
- `imem_rvalid`, input, 1: response valid; one pulse per request, one or more cycles after `imem_req`.
- `imem_rdata`, input, 32: instruction word; sampled only when `imem_rvalid`=1 in WAIT.
- `redirect_valid`, input, 1: taken branch/jump from execute.
- `redirect_pc`, input, XLEN: target; bits [1:0] are forced to 0 internally.
- `id_valid`, output, 1: IF/ID slot holds a valid instruction.
- `id_ready`, input, 1: decode accepts the slot this cycle.
- `id_instr`, output, 32: buffered instruction.
- `id_pc`, output, XLEN: address `id_instr` was fetched from.
- `id_opcode`, output, 7: equal to `id_instr[6:0]`; feeds the controller.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Reset state is IDLE. One outstanding request maximum.
- IDLE: unconditionally go to REQ next cycle.
- REQ: `imem_req`=1, `imem_addr`=pc. Go to WAIT.
- WAIT: on `imem_rvalid`, one of two cases:
  - `kill`=0: load `id_instr`←`imem_rdata`, `id_pc`←pc, `id_valid`←1, pc←pc+4 (mod 2^XLEN, wraps silently), go to HOLD.
  - `kill`=1: discard the data, clear `kill`, go to REQ.
- HOLD: `id_valid`=1. On `id_ready`=1, clear `id_valid` and go to REQ. Otherwise hold all outputs unchanged.
- Redirect (`redirect_valid`=1) has priority over everything in every state. Next cycle: pc←{redirect_pc[XLEN-1:2],2'b00}, `id_valid`←0, `id_instr`←32'h0000_0013 (NOP), `id_opcode`←7'b0010011. Next state depends on the current state:
  - IDLE/HOLD: go to REQ.
  - REQ: the request is still issued this cycle. Go to WAIT with `kill`←1.
  - WAIT without `imem_rvalid`: stay in WAIT with `kill`←1.
  - WAIT with `imem_rvalid` in the same cycle: response dropped, go to REQ, `kill`←0.
- Redirect in the same cycle as an HOLD handshake: the redirect wins. The slot is flushed and the handshake is treated as not occurred; decode must not act on it.
- `imem_rvalid` outside WAIT is ignored.
- `imem_addr` always shows pc; changes only at a redirect or after a non-killed response.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `id_valid`=0, `id_instr`=32'h0000_0013, `id_pc`=0, `id_opcode`=7'b0010011, `kill`=0, state IDLE.
- Reset asserted mid-operation: all of the above apply immediately (asynchronously). A response arriving after reset is ignored because the state is IDLE.
- Fetch latency: reset released before edge 0 → IDLE in cycle 0, `imem_req`=1 in cycle 1. With `imem_rvalid` in cycle 2, `id_valid`=1 in cycle 3. With `id_ready`=1 in cycle 3, the next `imem_req` is in cycle 4.
- Best-case throughput: one instruction per 3 cycles with 1-cycle memory. Each extra memory wait cycle adds one cycle.
- Redirect latency: redirect at cycle N → `imem_req` at the new PC in cycle N+1 (from IDLE/HOLD). From WAIT, it comes one cycle after the killed response.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset/boot: RESET_PC=0x100, memory returns 0x00500093 one cycle after each request, `id_ready`=1 → `imem_req` at cycle 1 with addr 0x100. `id_valid` at cycle 3 with `id_pc`=0x100, `id_opcode`=0x13. Next request addr is 0x104.
- Backpressure: hold `id_ready`=0 for 5 cycles in HOLD → `id_instr`, `id_pc`, `id_valid` constant and no `imem_req`. Raising `id_ready` gives `imem_req` next cycle.
- Redirect during WAIT (memory latency 3): `redirect_valid` with `redirect_pc`=0x203 in the first WAIT cycle → the stale response is dropped and `id_valid` stays 0. The next `imem_req` has addr 0x200, and the first delivered `id_pc` is 0x200.
- Simultaneous events: redirect and `imem_rvalid` in the same cycle → data discarded, `imem_req` next cycle at the target. Redirect and `id_ready` in HOLD → `id_valid` drops and no pc+4 request is issued.
- Wrap-around: XLEN=32, RESET_PC=0xFFFF_FFFC → second fetch address is 0x0000_0000.
- Async reset asserted in WAIT with a response pending → outputs go to reset values with no clock edge. A late `imem_rvalid` does not set `id_valid`.
